// File: rtl/prm_edge_mask_accum_pkg.sv
// Shared types and default sizes for the PRM blocked-edge collector.
// Contents: geometry defaults, FSM state enum, pipeline stage bundle.
package prm_pkg;

    localparam int CODE_W    = 15;
    localparam int NUM_EDGES = 64;
    localparam int OUT_W     = 32;
    localparam int CNT_W     = 16;

    localparam int NWORDS = NUM_EDGES / OUT_W;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Code-in-flight stage: the code sits on chk_code for one
    // cycle while the checker bank settles.
    typedef struct packed {
        logic valid;
        logic last;
    } s1_t;

endpackage

// File: rtl/prm_edge_mask_accum_drain.sv
// Drains the blocked-edge bitmap as OUT_W-bit words over valid/ready.
// Ports: clk/rst_n, start pulse, acc bitmap, out_* handshake, done pulse.
module prm_mask_drain
    import prm_pkg::*;
#(
    parameter int NUM_EDGES = prm_pkg::NUM_EDGES,
    parameter int OUT_W     = prm_pkg::OUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_EDGES-1:0] acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last,
    output logic                 done
);

    localparam int NW  = NUM_EDGES / OUT_W;
    localparam int IW  = (NW > 1) ? $clog2(NW) : 1;

    logic          active;
    logic [IW-1:0] word_idx;
    logic          hs;

    assign out_valid = active;
    assign out_last  = active && (word_idx == IW'(NW - 1));
    assign out_data  = acc[word_idx*OUT_W +: OUT_W];
    assign hs        = active && out_ready;
    assign done      = hs && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            word_idx <= '0;
        end else if (start) begin
            active   <= 1'b1;
            word_idx <= '0;
        end else if (done) begin
            active   <= 1'b0;
            word_idx <= '0;
        end else if (hs) begin
            word_idx <= word_idx + 1'b1;
        end
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Collects per-voxel edge masks from the checker bank into a frame bitmap.
// Ports: in_* code stream, chk_code/chk_mask bank bus, out_* drain, status.
module prm_edge_mask_accum
    import prm_pkg::*;
#(
    parameter int CODE_W    = prm_pkg::CODE_W,
    parameter int NUM_EDGES = prm_pkg::NUM_EDGES,
    parameter int OUT_W     = prm_pkg::OUT_W,
    parameter int CNT_W     = prm_pkg::CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
    input  logic                 in_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last,
    output logic [CNT_W-1:0]     frame_voxels,
    output logic                 busy
);

    state_e               state_q;
    state_e               state_d;
    s1_t                  s1;
    logic [NUM_EDGES-1:0] acc;
    logic [CNT_W-1:0]     voxel_cnt;
    logic                 accept;
    logic                 drain_done;

    // FSM: state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state_q <= ST_ACCUM;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: if (s1.last)    state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_ACCUM;
            default:                  state_d = ST_ACCUM;
        endcase
    end

    // FSM: outputs. in_ready depends only on registered state.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ST_ACCUM: in_ready = !s1.last;
            ST_DRAIN: in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            chk_code <= '0;
            s1       <= '0;
        end else begin
            s1.valid <= accept;
            s1.last  <= accept && in_last;
            if (accept) chk_code <= in_code;
        end
    end

    // The mask for the code on chk_code is sampled one cycle after
    // the accept, giving the combinational bank a full cycle to settle.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)          acc <= '0;
        else if (s1.valid)   acc <= acc | chk_mask;
        else if (drain_done) acc <= '0;
    end

    // No accept can coincide with s1.last, since in_ready is low then.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            voxel_cnt    <= '0;
            frame_voxels <= '0;
        end else if (s1.last) begin
            frame_voxels <= voxel_cnt;
            voxel_cnt    <= '0;
        end else if (accept && (voxel_cnt != '1)) begin
            voxel_cnt <= voxel_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)          busy <= 1'b0;
        else if (accept)     busy <= 1'b1;
        else if (drain_done) busy <= 1'b0;
    end

    prm_mask_drain #(
        .NUM_EDGES (NUM_EDGES),
        .OUT_W     (OUT_W)
    ) u_drain (
        .clk       (CLK),
        .rst_n     (RST_n),
        .start     (s1.last),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
- Frame-level collector that sits directly downstream of the PRM edge-check truth-table bank (the prm_oblgc_chk* modules).
- Accepts a stream of 15-bit obstacle voxel codes and drives each code onto the shared checker bus. One cycle later it captures the bank's combinational per-edge edge_mask vector and ORs it into a blocked-edge accumulator.
- At frame end it drains the accumulated blocked-edge bitmap as OUT_W-bit words over a valid/ready handshake to the roadmap/graph-search logic.

Parameters:
CODE_W, 15, width of voxel code (checker inputs A..O; bit 0 = A, bit 14 = O)
NUM_EDGES, 64, number of checker instances = width of mask vector; must be a multiple of OUT_W
OUT_W, 32, drain word width
CNT_W, 16, width of per-frame voxel counter

Ports:
CLK  in  1  clock; all state rising-edge
RST_n  in  1  reset, asynchronous, active-low
in_valid  in  1  voxel code valid
in_ready  out  1  block can accept a code
in_code  in  CODE_W  voxel code
in_last  in  1  final voxel of frame (qualified by in_valid)
chk_code  out  CODE_W  registered code driven to every checker instance
chk_mask  in  NUM_EDGES  edge_mask outputs of the checker bank; bit e = checker e
out_valid  out  1  drain word valid
out_ready  in  1  consumer accepts word
out_data  out  OUT_W  drain word
out_last  out  1  final word of frame
frame_voxels  out  CNT_W  voxels accepted in last completed frame, stable while draining
busy  out  1  high from first accepted code until final drain handshake

Behaviour:
- Reset (async, RST_n=0): state=ACCUM, acc=0, chk_code=0, s1_valid=0, s1_last=0, word_idx=0, voxel_cnt=0, frame_voxels=0.
  - Outputs at reset: out_valid=0, out_last=0, busy=0, in_ready=1 once RST_n deasserts.
- States: ACCUM, DRAIN.
- ACCUM:
  - in_ready = 1 unless a last code is in flight (s1_last=1), in which case in_ready = 0.
  - Accept on in_valid & in_ready at edge k: chk_code<=in_code, s1_valid<=1, s1_last<=in_last, voxel_cnt<=voxel_cnt+1 (saturates at all-ones), busy<=1.
  - No accept at edge k: s1_valid<=0, s1_last<=0; chk_code holds.
  - Edge k+1, if s1_valid: acc<=acc|chk_mask. The checker bank is purely combinational, so exactly one cycle of chk_code-to-chk_mask settling is required and budgeted.
  - Edge k+1, if s1_last: state<=DRAIN, word_idx<=0, frame_voxels<=voxel_cnt, voxel_cnt<=0. The final OR still applies on this edge.
  - Back-to-back codes at full throughput (one per cycle) are supported.
- DRAIN:
  - in_ready=0; out_valid=1; out_data = acc[word_idx*OUT_W +: OUT_W], word 0 = edges 0..OUT_W-1.
  - out_last = (word_idx == NUM_EDGES/OUT_W-1).
  - On handshake (out_valid & out_ready): word_idx increments.
  - On last-word handshake: acc<=0, busy<=0, state<=ACCUM.
  - out_data and out_last hold stable while out_ready=0.
- Latency: last code accepted at edge k -> out_valid high after edge k+1 -> first word can transfer at edge k+2.
- Frame minimum is 1 voxel. in_last on a code sets the frame end; there is no empty-frame case.
- in_valid during DRAIN is ignored and not accepted; the upstream holds its data per valid/ready rules.
- Reset asserted mid-frame or mid-drain: all state clears immediately. A partial frame is discarded and no words are emitted.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Decomposition:
- Shared package prm_pkg holds:
  - CODE_W, NUM_EDGES, OUT_W, CNT_W defaults;
  - state enum {ST_ACCUM, ST_DRAIN};
  - localparam NWORDS = NUM_EDGES/OUT_W and word-index width $clog2(NWORDS).
- Sub-module prm_mask_drain: takes acc plus a start pulse, owns word_idx and the out_* handshake, and signals done.
- The checker bank stays outside this block and is instantiated alongside it by the integrating top.

Test Plan:
- Single-voxel frame: in_code=15'h4001, in_last=1; bench model sets chk_mask=64'h1 for that code -> out words 32'h1 then 32'h0 (out_last on 2nd); frame_voxels=1.
- Three back-to-back voxels with masks 64'h1, 64'h0000_0002_0000_0000, 64'h8000_0000_0000_0000, last on 3rd -> words 32'h1, 32'h8000_0002; in_ready=0 from the edge after the 3rd accept until the 2nd word handshake; frame_voxels=3.
- Drain backpressure: out_ready held 0 for 5 cycles -> out_valid stays 1 and out_data stays constant; in_valid pulses are not accepted; words emitted in order once out_ready=1.
- Accumulator clear between frames: frame A masks 64'hFFFF..., then frame B a single voxel with mask 0 -> frame B words are 32'h0, 32'h0.
- Reset mid-drain: RST_n=0 after word 0 transfers -> out_valid drops asynchronously, busy=0; the next frame of mask 64'h4 drains as 32'h4, 32'h0.
- Voxel-count saturation with CNT_W=4: 20-voxel frame -> frame_voxels=4'hF.
